axi_lite_ctrl_regs: RTL and testbench

AXI4-Lite responder holding the accelerator's control/status registers: kernel size, channel counts, function/stride/output width, and the instruction byte that launches compute, ifmap load or weight write. It sits between the host's AXI4-Lite master and the data path. It turns register writes into configuration buses and single-cycle start pulses, and returns done status on reads.

---
 rtl/axi_lite_ctrl_regs.sv | 178 +++++++++++++++++
 tb/tb_axi_lite_ctrl_regs.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register file for the accelerator: configuration registers,
// instruction-triggered start pulses and sticky done flags readable by the host.
`timescale 1ns/1ps
module axi_lite_ctrl_regs #(
  parameter int         C_S_AXI_DATA_WIDTH = 32,
  parameter int         C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [7:0] INST_COMPUTE       = 8'd87,
  parameter logic [7:0] INST_LOADIFMAPS    = 8'd88,
  parameter logic [7:0] INST_WRITE_WEIGHT  = 8'd12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [11:0]                     ofmaps_channel,
  output logic [11:0]                     input_channel,
  output logic [1:0]                      func,
  output logic [8:0]                      ofmaps_width,
  output logic [2:0]                      stride,
  output logic [4:0]                      kernel_size,
  output logic                            compute_start,
  output logic                            load_ifmaps_start,
  output logic                            write_weight_start,
  input  logic                            compute_done_in,
  input  logic                            write_weight_done_in,
  input  logic                            busy_in
);

  logic        r_awready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [31:0] r_reg0;
  logic [13:0] r_reg1;
  logic [4:0]  r_reg2;
  logic        r_ww_done;
  logic        r_comp_done;
  logic        r_compute_start;
  logic        r_load_start;
  logic        r_ww_start;

  logic        w_wr_en;
  logic        w_rd_en;
  logic [1:0]  w_wr_sel;
  logic [1:0]  w_rd_sel;
  logic        w_inst_wr;
  logic        w_ww_clr;
  logic        w_comp_clr;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr_sel   = S_AXI_AWADDR[3:2];
  assign w_rd_sel   = S_AXI_ARADDR[3:2];
  assign w_wr_en    = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_en    = r_arready & S_AXI_ARVALID;
  assign w_inst_wr  = w_wr_en & (w_wr_sel == 2'd0) & S_AXI_WSTRB[0];
  assign w_ww_clr   = w_wr_en & (w_wr_sel == 2'd3) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign w_comp_clr = w_wr_en & (w_wr_sel == 2'd3) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign w_unused   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Address and data are only taken together, and never while a response is still owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= ~r_awready & ~r_bvalid & S_AXI_AWVALID & S_AXI_WVALID;
      if (w_wr_en)
        r_bvalid <= 1'b1;
      else if (S_AXI_BREADY)
        r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg0 <= '0;
      r_reg1 <= '0;
      r_reg2 <= '0;
    end else if (w_wr_en) begin
      case (w_wr_sel)
        2'd0: begin
          for (int i = 0; i < 4; i++)
            if (S_AXI_WSTRB[i]) r_reg0[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
        end
        2'd1: begin
          if (S_AXI_WSTRB[0]) r_reg1[7:0]  <= S_AXI_WDATA[7:0];
          if (S_AXI_WSTRB[1]) r_reg1[13:8] <= S_AXI_WDATA[13:8];
        end
        2'd2: begin
          if (S_AXI_WSTRB[0]) r_reg2 <= S_AXI_WDATA[4:0];
        end
        default: ;
      endcase
    end
  end

  // Every instruction-byte write re-evaluates the opcode, so repeating one relaunches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compute_start <= 1'b0;
      r_load_start    <= 1'b0;
      r_ww_start      <= 1'b0;
      r_ww_done       <= 1'b0;
      r_comp_done     <= 1'b0;
    end else begin
      r_compute_start <= w_inst_wr & (S_AXI_WDATA[7:0] == INST_COMPUTE);
      r_load_start    <= w_inst_wr & (S_AXI_WDATA[7:0] == INST_LOADIFMAPS);
      r_ww_start      <= w_inst_wr & (S_AXI_WDATA[7:0] == INST_WRITE_WEIGHT);
      r_ww_done       <= write_weight_done_in | (r_ww_done & ~w_ww_clr);
      r_comp_done     <= compute_done_in | (r_comp_done & ~w_comp_clr);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_rd_sel)
      2'd0:    w_rd_mux = r_reg0;
      2'd1:    w_rd_mux = {18'd0, r_reg1};
      2'd2:    w_rd_mux = {27'd0, r_reg2};
      default: w_rd_mux = {29'd0, busy_in, r_comp_done, r_ww_done};
    endcase
  end

  // Read data is snapshotted at acceptance and held until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & ~r_rvalid & S_AXI_ARVALID;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY      = r_awready;
  assign S_AXI_WREADY       = r_awready;
  assign S_AXI_BVALID       = r_bvalid;
  assign S_AXI_BRESP        = 2'b00;
  assign S_AXI_ARREADY      = r_arready;
  assign S_AXI_RVALID       = r_rvalid;
  assign S_AXI_RDATA        = r_rdata;
  assign S_AXI_RRESP        = 2'b00;
  assign ofmaps_channel     = r_reg0[31:20];
  assign input_channel      = r_reg0[19:8];
  assign func               = r_reg1[1:0];
  assign ofmaps_width       = r_reg1[10:2];
  assign stride             = r_reg1[13:11];
  assign kernel_size        = r_reg2;
  assign compute_start      = r_compute_start;
  assign load_ifmaps_start  = r_load_start;
  assign write_weight_start = r_ww_start;

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Directed bench for axi_lite_ctrl_regs: register writes, start pulses, sticky status,
// concurrent read/write and reset in the middle of a transaction.
`timescale 1ns/1ps
module tb_axi_lite_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [11:0] ofmaps_channel;
  logic [11:0] input_channel;
  logic [1:0]  func;
  logic [8:0]  ofmaps_width;
  logic [2:0]  stride;
  logic [4:0]  kernel_size;
  logic        compute_start;
  logic        load_ifmaps_start;
  logic        write_weight_start;
  logic        compute_done_in;
  logic        write_weight_done_in;
  logic        busy_in;

  int checksPassed = 0;
  int checksTotal  = 0;
  int nCompute = 0;
  int nLoad    = 0;
  int nWw      = 0;

  axi_lite_ctrl_regs dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .ofmaps_channel(ofmaps_channel), .input_channel(input_channel), .func(func),
    .ofmaps_width(ofmaps_width), .stride(stride), .kernel_size(kernel_size),
    .compute_start(compute_start), .load_ifmaps_start(load_ifmaps_start),
    .write_weight_start(write_weight_start),
    .compute_done_in(compute_done_in), .write_weight_done_in(write_weight_done_in),
    .busy_in(busy_in)
  );

  always #5 clk = ~clk;

  // Pulse widths are measured by counting the falling edges each start output is high.
  always @(negedge clk) begin
    if (compute_start)      nCompute++;
    if (load_ifmaps_start)  nLoad++;
    if (write_weight_start) nWw++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'b0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    compute_done_in = 1'b0; write_weight_done_in = 1'b0; busy_in = 1'b0;
  endtask

  // Master keeps both valids up until it sees BVALID, then acknowledges the response.
  task automatic axiWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int readyCycles, output bit gotB, output logic [1:0] bresp,
                          output logic [2:0] startsAtB);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    readyCycles = 0; gotB = 1'b0; bresp = 2'bxx; startsAtB = 3'b000;
    for (int i = 0; i < 16 && !gotB; i++) begin
      @(posedge clk); #1;
      if (S_AXI_AWREADY && S_AXI_WREADY) readyCycles++;
      if (S_AXI_BVALID) begin
        gotB = 1'b1;
        bresp = S_AXI_BRESP;
        startsAtB = {write_weight_start, load_ifmaps_start, compute_start};
      end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axiRead(input logic [3:0] a, input int hold, output logic [31:0] data,
                         output logic [1:0] rresp, output bit gotR, output bit stable);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    gotR = 1'b0; stable = 1'b1; data = 32'hx; rresp = 2'bxx;
    for (int i = 0; i < 16 && !gotR; i++) begin
      @(posedge clk); #1;
      if (S_AXI_RVALID) begin
        gotR = 1'b1; data = S_AXI_RDATA; rresp = S_AXI_RRESP;
      end
    end
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!S_AXI_RVALID || S_AXI_RDATA !== data) stable = 1'b0;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic dualOp(input logic [3:0] ra, input logic [3:0] wa, input logic [31:0] wd,
                        output bit bothReady, output bit bothValid, output logic [31:0] rdata,
                        output logic [3:0] resps);
    S_AXI_ARADDR = ra; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = wa; S_AXI_WDATA = wd; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    bothReady = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_ARREADY;
    @(posedge clk); #1;
    bothValid = S_AXI_BVALID && S_AXI_RVALID;
    rdata = S_AXI_RDATA; resps = {S_AXI_BRESP, S_AXI_RRESP};
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checksTotal++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
         compute_start, load_ifmaps_start, write_weight_start} !== 8'h00)
      $display("[TB] FAIL reset_handshake: got %b want 00000000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                compute_start, load_ifmaps_start, write_weight_start});
    else checksPassed++;
    checksTotal++;
    if ({ofmaps_channel, input_channel, func, ofmaps_width, stride, kernel_size} !== 43'd0)
      $display("[TB] FAIL reset_config: got %h want 0",
               {ofmaps_channel, input_channel, func, ofmaps_width, stride, kernel_size});
    else checksPassed++;
    checksTotal++;
    if (S_AXI_RDATA !== 32'h0) $display("[TB] FAIL reset_rdata: got %h want 0", S_AXI_RDATA);
    else checksPassed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_kernel_write();
    int rc; bit gb; logic [1:0] br; logic [2:0] sab;
    int c0, l0, w0;
    c0 = nCompute; l0 = nLoad; w0 = nWw;
    axiWrite(4'h8, 32'h0000_0002, 4'hF, rc, gb, br, sab);
    checksTotal++;
    if (rc !== 1) $display("[TB] FAIL kw_ready_count: got %0d want 1", rc); else checksPassed++;
    checksTotal++;
    if (gb !== 1'b1) $display("[TB] FAIL kw_bvalid_seen: got %0d want 1", gb); else checksPassed++;
    checksTotal++;
    if (br !== 2'b00) $display("[TB] FAIL kw_bresp: got %b want 00", br); else checksPassed++;
    checksTotal++;
    if (kernel_size !== 5'b00010) $display("[TB] FAIL kw_kernel: got %b want 00010", kernel_size);
    else checksPassed++;
    checksTotal++;
    if (S_AXI_BVALID !== 1'b0) $display("[TB] FAIL kw_bvalid_clear: got %b want 0", S_AXI_BVALID);
    else checksPassed++;
    checksTotal++;
    if ((nCompute - c0) + (nLoad - l0) + (nWw - w0) !== 0)
      $display("[TB] FAIL kw_no_pulse: got %0d pulse cycles want 0",
               (nCompute - c0) + (nLoad - l0) + (nWw - w0));
    else checksPassed++;
    axiWrite(4'h8, 32'h0000_0004, 4'h0, rc, gb, br, sab);
    checksTotal++;
    if (kernel_size !== 5'b00010) $display("[TB] FAIL kw_strb_zero: got %b want 00010", kernel_size);
    else checksPassed++;
  endtask

  task automatic test_config();
    int rc; bit gb; logic [1:0] br; logic [2:0] sab;
    logic [31:0] rd; logic [1:0] rr; bit gr, st;
    int c0, l0, w0;
    c0 = nCompute; l0 = nLoad; w0 = nWw;
    axiWrite(4'h0, {12'd2, 12'd2, 8'd0}, 4'b1110, rc, gb, br, sab);
    axiWrite(4'h4, {18'd0, 3'd2, 9'd3, 2'd1}, 4'hF, rc, gb, br, sab);
    checksTotal++;
    if ({ofmaps_channel, input_channel} !== {12'd2, 12'd2})
      $display("[TB] FAIL cfg_channels: got %0d/%0d want 2/2", ofmaps_channel, input_channel);
    else checksPassed++;
    checksTotal++;
    if ({func, ofmaps_width, stride} !== {2'd1, 9'd3, 3'd2})
      $display("[TB] FAIL cfg_reg1: got func=%0d width=%0d stride=%0d want 1/3/2",
               func, ofmaps_width, stride);
    else checksPassed++;
    checksTotal++;
    if ((nCompute - c0) + (nLoad - l0) + (nWw - w0) !== 0)
      $display("[TB] FAIL cfg_no_pulse: got %0d pulse cycles want 0",
               (nCompute - c0) + (nLoad - l0) + (nWw - w0));
    else checksPassed++;
    axiWrite(4'h4, 32'hFFFF_D00D, 4'hF, rc, gb, br, sab);
    axiRead(4'h4, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h0000_100D) $display("[TB] FAIL cfg_reg1_read: got %h want 0000100d", rd);
    else checksPassed++;
    axiRead(4'h0, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h0020_0200) $display("[TB] FAIL cfg_reg0_read: got %h want 00200200", rd);
    else checksPassed++;
  endtask

  task automatic test_start_pulses();
    int rc; bit gb; logic [1:0] br; logic [2:0] sab;
    logic [31:0] rd; logic [1:0] rr; bit gr, st;
    int c0, l0, w0;
    c0 = nCompute; l0 = nLoad; w0 = nWw;
    axiWrite(4'h0, 32'h0000_0057, 4'b0001, rc, gb, br, sab);
    checksTotal++;
    if (sab !== 3'b001) $display("[TB] FAIL sp_compute_at_b: got %b want 001", sab); else checksPassed++;
    checksTotal++;
    if ({nCompute - c0, nLoad - l0, nWw - w0} !== {32'd1, 32'd0, 32'd0})
      $display("[TB] FAIL sp_compute_width: got %0d/%0d/%0d want 1/0/0",
               nCompute - c0, nLoad - l0, nWw - w0);
    else checksPassed++;
    checksTotal++;
    if ({ofmaps_channel, input_channel} !== {12'd2, 12'd2})
      $display("[TB] FAIL sp_channels_kept: got %0d/%0d want 2/2", ofmaps_channel, input_channel);
    else checksPassed++;
    axiWrite(4'h0, 32'h0000_000C, 4'b0001, rc, gb, br, sab);
    checksTotal++;
    if (sab !== 3'b100) $display("[TB] FAIL sp_weight_at_b: got %b want 100", sab); else checksPassed++;
    axiWrite(4'h0, 32'h0000_0058, 4'b0001, rc, gb, br, sab);
    checksTotal++;
    if (sab !== 3'b010) $display("[TB] FAIL sp_load_at_b: got %b want 010", sab); else checksPassed++;
    c0 = nCompute; l0 = nLoad; w0 = nWw;
    axiWrite(4'h0, 32'h0000_0005, 4'b0001, rc, gb, br, sab);
    checksTotal++;
    if ((nCompute - c0) + (nLoad - l0) + (nWw - w0) !== 0)
      $display("[TB] FAIL sp_bad_opcode: got %0d pulse cycles want 0",
               (nCompute - c0) + (nLoad - l0) + (nWw - w0));
    else checksPassed++;
    c0 = nCompute;
    axiWrite(4'h0, 32'h0000_0057, 4'b0001, rc, gb, br, sab);
    axiWrite(4'h0, 32'h0000_0057, 4'b0001, rc, gb, br, sab);
    checksTotal++;
    if (nCompute - c0 !== 2) $display("[TB] FAIL sp_repeat: got %0d want 2", nCompute - c0);
    else checksPassed++;
    c0 = nCompute; l0 = nLoad; w0 = nWw;
    axiWrite(4'h0, 32'h0000_0058, 4'b1110, rc, gb, br, sab);
    checksTotal++;
    if ((nCompute - c0) + (nLoad - l0) + (nWw - w0) !== 0)
      $display("[TB] FAIL sp_no_strb0: got %0d pulse cycles want 0",
               (nCompute - c0) + (nLoad - l0) + (nWw - w0));
    else checksPassed++;
    axiRead(4'h0, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h0000_0057) $display("[TB] FAIL sp_inst_untouched: got %h want 00000057", rd);
    else checksPassed++;
  endtask

  task automatic test_sticky();
    int rc; bit gb; logic [1:0] br; logic [2:0] sab;
    logic [31:0] rd; logic [1:0] rr; bit gr, st;
    write_weight_done_in = 1'b1;
    @(posedge clk); #1;
    write_weight_done_in = 1'b0;
    axiRead(4'hC, 3, rd, rr, gr, st);
    checksTotal++;
    if ({gr, rr, rd} !== {1'b1, 2'b00, 32'h1})
      $display("[TB] FAIL st_ww_set: got valid=%0d resp=%b data=%h want 1/00/00000001", gr, rr, rd);
    else checksPassed++;
    checksTotal++;
    if (st !== 1'b1) $display("[TB] FAIL st_rdata_hold: got stable=%0d want 1", st); else checksPassed++;
    axiWrite(4'hC, 32'h1, 4'hF, rc, gb, br, sab);
    axiRead(4'hC, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h0) $display("[TB] FAIL st_ww_clear: got %h want 0", rd); else checksPassed++;
    compute_done_in = 1'b1;
    @(posedge clk); #1;
    compute_done_in = 1'b0;
    axiWrite(4'hC, 32'h1, 4'hF, rc, gb, br, sab);
    axiRead(4'hC, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h2) $display("[TB] FAIL st_comp_kept: got %h want 00000002", rd); else checksPassed++;
    axiWrite(4'hC, 32'h2, 4'hF, rc, gb, br, sab);
    busy_in = 1'b1;
    axiRead(4'hC, 0, rd, rr, gr, st);
    busy_in = 1'b0;
    checksTotal++;
    if (rd !== 32'h4) $display("[TB] FAIL st_busy_live: got %h want 00000004", rd); else checksPassed++;
    // Done pulse lands in the same cycle the clear is accepted.
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    checksTotal++;
    if (S_AXI_AWREADY !== 1'b1) $display("[TB] FAIL st_race_ready: got %b want 1", S_AXI_AWREADY);
    else checksPassed++;
    write_weight_done_in = 1'b1;
    @(posedge clk); #1;
    write_weight_done_in = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    axiRead(4'hC, 0, rd, rr, gr, st);
    checksTotal++;
    if (rd !== 32'h1) $display("[TB] FAIL st_set_wins: got %h want 00000001", rd); else checksPassed++;
  endtask

  task automatic test_back_to_back();
    bit br2, bv2; logic [31:0] rd; logic [3:0] rs;
    logic [31:0] rd2; logic [1:0] rr; bit gr, st;
    dualOp(4'hC, 4'hC, 32'h1, br2, bv2, rd, rs);
    checksTotal++;
    if ({br2, bv2, rs} !== {1'b1, 1'b1, 4'b0000})
      $display("[TB] FAIL bb_w1c_handshake: got ready=%0d valid=%0d resps=%b want 1/1/0000", br2, bv2, rs);
    else checksPassed++;
    checksTotal++;
    if (rd !== 32'h1) $display("[TB] FAIL bb_preclear_read: got %h want 00000001", rd); else checksPassed++;
    axiRead(4'hC, 0, rd2, rr, gr, st);
    checksTotal++;
    if (rd2 !== 32'h0) $display("[TB] FAIL bb_cleared: got %h want 0", rd2); else checksPassed++;
    dualOp(4'h8, 4'h4, 32'h0000_0805, br2, bv2, rd, rs);
    checksTotal++;
    if ({br2, bv2, rs, rd} !== {1'b1, 1'b1, 4'b0000, 32'h2})
      $display("[TB] FAIL bb_rw_mix: got ready=%0d valid=%0d resps=%b data=%h want 1/1/0000/00000002",
               br2, bv2, rs, rd);
    else checksPassed++;
    checksTotal++;
    if ({func, ofmaps_width, stride} !== {2'd1, 9'd1, 3'd1})
      $display("[TB] FAIL bb_reg1_written: got func=%0d width=%0d stride=%0d want 1/1/1",
               func, ofmaps_width, stride);
    else checksPassed++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic [1:0] rr; bit gr, st;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0000_0058; S_AXI_WSTRB = 4'b0001;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checksTotal++;
    if ({S_AXI_BVALID, load_ifmaps_start} !== 2'b11)
      $display("[TB] FAIL rm_pending: got bvalid/load=%b want 11", {S_AXI_BVALID, load_ifmaps_start});
    else checksPassed++;
    #2 rst = 1'b1;
    #1;
    checksTotal++;
    if ({S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
         compute_start, load_ifmaps_start, write_weight_start} !== 7'd0)
      $display("[TB] FAIL rm_handshake: got %b want 0000000",
               {S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                compute_start, load_ifmaps_start, write_weight_start});
    else checksPassed++;
    checksTotal++;
    if ({ofmaps_channel, input_channel, func, ofmaps_width, stride, kernel_size, S_AXI_RDATA} !== 75'd0)
      $display("[TB] FAIL rm_state: got %h want 0",
               {ofmaps_channel, input_channel, func, ofmaps_width, stride, kernel_size, S_AXI_RDATA});
    else checksPassed++;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    axiRead(4'h4, 0, rd, rr, gr, st);
    checksTotal++;
    if ({gr, rr, rd} !== {1'b1, 2'b00, 32'h0})
      $display("[TB] FAIL rm_fresh_read: got valid=%0d resp=%b data=%h want 1/00/0", gr, rr, rd);
    else checksPassed++;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_kernel_write();
    test_config();
    test_start_pulses();
    test_sticky();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
